// File: rtl/alu_64_arbiter.sv
// alu_64_arbiter: shares one 64-bit ALU between two requesters.
// Round-robin arbitration between the requesters, one operation in flight at a time.
// Each operation takes three stages: accept, execute from latched operands, respond.
// Each port keeps its own response registers, so a port's result, flags and err
// are not changed by operations on the other port.
module alu_64_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_funct,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_funct,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_result,
    output logic [5:0]  rsp0_flags,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_result,
    output logic [5:0]  rsp1_flags,
    output logic        rsp1_err
);

    localparam logic [2:0] FnLoad = 3'd0;
    localparam logic [2:0] FnSum  = 3'd1;
    localparam logic [2:0] FnSub  = 3'd2;
    localparam logic [2:0] FnAnd  = 3'd3;
    localparam logic [2:0] FnXor  = 3'd4;
    localparam logic [2:0] FnNot  = 3'd5;
    localparam logic [2:0] FnInc  = 3'd6;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        gnt_q;
    logic [2:0]  funct_q;
    logic [63:0] a_q, b_q;
    logic [63:0] res0_q, res1_q;
    logic [5:0]  flags0_q, flags1_q;
    logic        err0_q, err1_q;

    logic        win;
    logic        accept;
    logic        rsp_fire;
    logic [63:0] alu_res;
    logic [5:0]  alu_flags;
    logic        alu_ovf;
    logic        alu_err;

    // Arbitration: pick the winner from the valids and prio; grant only in IDLE.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = prio_q;
        end else if (req1_valid) begin
            win = 1'b1;
        end
        accept     = (state_q == StIdle) && !reset && (req0_valid || req1_valid);
        req0_ready = accept && !win;
        req1_ready = accept && win;
    end

    assign rsp_fire = (state_q == StResp) && (gnt_q ? rsp1_ready : rsp0_ready);

    // Next-state logic; prio moves to the port not just served on a response handshake.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: state_d = StResp;
            StResp: begin
                if (rsp_fire) begin
                    state_d = StIdle;
                    prio_d  = ~gnt_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ALU driven purely from the latched operands; illegal funct zeroes result and flags.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (funct_q)
            FnLoad: alu_res = a_q;
            FnSum: begin
                alu_res = a_q + b_q;
                alu_ovf = (a_q[63] == b_q[63]) && (alu_res[63] != a_q[63]);
            end
            FnSub: begin
                alu_res = a_q - b_q;
                alu_ovf = (a_q[63] != b_q[63]) && (alu_res[63] != a_q[63]);
            end
            FnAnd: alu_res = a_q & b_q;
            FnXor: alu_res = a_q ^ b_q;
            FnNot: alu_res = ~a_q;
            FnInc: begin
                alu_res = a_q + 64'd1;
                alu_ovf = !a_q[63] && alu_res[63];
            end
            default: alu_err = 1'b1;
        endcase
        if (alu_err) begin
            alu_flags = '0;
        end else begin
            alu_flags = {alu_ovf, alu_res[63], alu_res == '0, a_q == b_q,
                         $signed(a_q) > $signed(b_q), $signed(a_q) < $signed(b_q)};
        end
    end

    // Control state: FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            prio_q  <= RR_INIT;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Datapath: latch the winner's operation on accept, capture the ALU output in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q    <= 1'b0;
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            flags0_q <= '0;
            flags1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            if (accept) begin
                gnt_q   <= win;
                funct_q <= win ? req1_funct : req0_funct;
                a_q     <= win ? req1_a : req0_a;
                b_q     <= win ? req1_b : req0_b;
            end
            if (state_q == StExec) begin
                if (gnt_q) begin
                    res1_q   <= alu_res;
                    flags1_q <= alu_flags;
                    err1_q   <= alu_err;
                end else begin
                    res0_q   <= alu_res;
                    flags0_q <= alu_flags;
                    err0_q   <= alu_err;
                end
            end
        end
    end

    assign rsp0_valid  = (state_q == StResp) && !gnt_q;
    assign rsp1_valid  = (state_q == StResp) && gnt_q;
    assign rsp0_result = res0_q;
    assign rsp0_flags  = flags0_q;
    assign rsp0_err    = err0_q;
    assign rsp1_result = res1_q;
    assign rsp1_flags  = flags1_q;
    assign rsp1_err    = err1_q;

endmodule

// File: tb/tb_alu_64_arbiter.sv
// Self-checking bench for alu_64_arbiter: directed scenarios plus randomized
// traffic checked against an arithmetic reference model and a round-robin model.
module tb_alu_64_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_funct, req1_funct;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp0_result, rsp1_result;
    logic [5:0]  rsp0_flags, rsp1_flags;
    logic        rsp0_err, rsp1_err;

    int n_assert;
    int n_fail;
    int prio_m;

    alu_64_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_funct (req0_funct),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_funct (req1_funct),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_result(rsp0_result),
        .rsp0_flags (rsp0_flags),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_result(rsp1_result),
        .rsp1_flags (rsp1_flags),
        .rsp1_err   (rsp1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU computed with wide signed arithmetic.
    task automatic model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [5:0] fl, output logic e);
        longint sa, sb;
        logic signed [65:0] wa, wb, wide;
        logic ovf;
        sa = a;
        sb = b;
        wa = sa;
        wb = sb;
        wide = '0;
        ovf = 1'b0;
        e = 1'b0;
        r = '0;
        case (f)
            3'd0: r = a;
            3'd1: begin wide = wa + wb; r = wide[63:0]; ovf = (wide != {{2{r[63]}}, r}); end
            3'd2: begin wide = wa - wb; r = wide[63:0]; ovf = (wide != {{2{r[63]}}, r}); end
            3'd3: r = a & b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin wide = wa + 66'sd1; r = wide[63:0]; ovf = (wide != {{2{r[63]}}, r}); end
            default: e = 1'b1;
        endcase
        if (e) fl = '0;
        else fl = {ovf, r[63], r == 64'd0, sa == sb, sa > sb, sa < sb};
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] f,
                           input logic [63:0] a, input logic [63:0] b);
        if (p == 0) begin
            req0_valid = v; req0_funct = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_funct = f; req1_a = a; req1_b = b;
        end
    endtask

    task automatic check_rsp(input int p, input logic [63:0] er, input logic [5:0] ef,
                             input logic ee, input string tag);
        if (p == 0) begin
            chk({tag, "_v0"}, rsp0_valid, 1);
            chk({tag, "_v1"}, rsp1_valid, 0);
            chk({tag, "_res"}, rsp0_result, er);
            chk({tag, "_flags"}, rsp0_flags, ef);
            chk({tag, "_err"}, rsp0_err, ee);
        end else begin
            chk({tag, "_v1"}, rsp1_valid, 1);
            chk({tag, "_v0"}, rsp0_valid, 0);
            chk({tag, "_res"}, rsp1_result, er);
            chk({tag, "_flags"}, rsp1_flags, ef);
            chk({tag, "_err"}, rsp1_err, ee);
        end
    endtask

    // Called at the negedge right after the accept edge, winner's valid already dropped.
    task automatic finish_op(input int p, input logic [63:0] er, input logic [5:0] ef,
                             input logic ee, input int delay, input string tag);
        chk({tag, "_exec_v0"}, rsp0_valid, 0);
        chk({tag, "_exec_v1"}, rsp1_valid, 0);
        chk({tag, "_exec_rdy0"}, req0_ready, 0);
        chk({tag, "_exec_rdy1"}, req1_ready, 0);
        if (p == 0) rsp0_ready = (delay == 0);
        else rsp1_ready = (delay == 0);
        @(negedge clk);
        check_rsp(p, er, ef, ee, tag);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_rsp(p, er, ef, ee, {tag, "_hold"});
            chk({tag, "_hold_rdy0"}, req0_ready, 0);
            chk({tag, "_hold_rdy1"}, req1_ready, 0);
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_v0"}, rsp0_valid, 0);
        chk({tag, "_idle_v1"}, rsp1_valid, 0);
        prio_m = (p == 0) ? 1 : 0;
    endtask

    // Single requester issue from an IDLE negedge through response handshake.
    task automatic lone_op(input int p, input logic [2:0] f, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] er, input logic [5:0] ef,
                           input logic ee, input int delay, input string tag);
        set_req(p, 1'b1, f, a, b);
        #1;
        chk({tag, "_rdy"}, (p == 0) ? req0_ready : req1_ready, 1);
        chk({tag, "_rdy_other"}, (p == 0) ? req1_ready : req0_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(p, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(p, er, ef, ee, delay, tag);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 20));
            2: return $urandom_range(0, 1) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
            default: return -64'($urandom_range(1, 20));
        endcase
    endfunction

    initial begin
        logic [63:0] er, a0, b0, a1, b1;
        logic [5:0]  ef;
        logic        ee;
        logic [2:0]  f0, f1;
        int          w, l, d;

        n_assert = 0;
        n_fail = 0;
        prio_m = 0;
        reset = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 3'd1, 64'd1, 64'd1);
        set_req(1, 1'b1, 3'd1, 64'd1, 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_v0", rsp0_valid, 0);
        chk("rst_v1", rsp1_valid, 0);
        chk("rst_res0", rsp0_result, 0);
        chk("rst_res1", rsp1_result, 0);
        chk("rst_flags0", rsp0_flags, 0);
        chk("rst_flags1", rsp1_flags, 0);
        chk("rst_err0", rsp0_err, 0);
        chk("rst_err1", rsp1_err, 0);
        set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: sum less-than, sub to zero, lone port 1 back-to-back, overflow.
        lone_op(0, 3'd1, 64'd12, 64'd25, 64'd37, 6'b000001, 1'b0, 0, "sum");
        lone_op(1, 3'd2, 64'd54, 64'd54, 64'd0, 6'b001100, 1'b0, 0, "sub0");
        lone_op(1, 3'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000,
                6'b110010, 1'b0, 0, "inc_ovf");
        lone_op(0, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 64'h8000_0000_0000_0002,
                6'b110010, 1'b0, 0, "sum_ovf");

        // Arbitration after a reset pulse: prio returns to port 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prio_m = 0;
        set_req(0, 1'b1, 3'd4, 64'd12, 64'd25);
        set_req(1, 1'b1, 3'd6, 64'd2, 64'd0);
        #1;
        chk("arb_rdy0", req0_ready, 1);
        chk("arb_rdy1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(0, 64'd21, 6'b000001, 1'b0, 0, "arb_xor");
        chk("arb_p1_rdy", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(1, 64'd3, 6'b000010, 1'b0, 0, "arb_inc");
        set_req(0, 1'b1, 3'd3, 64'hF0, 64'h3C);
        set_req(1, 1'b1, 3'd3, 64'hF0, 64'h3C);
        #1;
        chk("arb3_rdy0", req0_ready, 1);
        chk("arb3_rdy1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(0, 64'h30, 6'b000010, 1'b0, 0, "arb3");

        // Backpressure on rsp0 for 5 cycles while port 1 waits.
        set_req(0, 1'b1, 3'd5, 64'd0, 64'd0);
        #1;
        chk("bp_rdy0", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
        set_req(1, 1'b1, 3'd1, 64'd5, 64'd6);
        finish_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 6'b010100, 1'b0, 5, "bp");
        chk("bp_p1_rdy", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(1, 64'd11, 6'b000001, 1'b0, 0, "bp_p1");

        // Reset during EXEC of a port 1 op while prio points at port 1.
        lone_op(0, 3'd0, 64'd9, 64'd9, 64'd9, 6'b000100, 1'b0, 0, "load");
        set_req(1, 1'b1, 3'd1, 64'd1, 64'd1);
        #1;
        chk("rexec_rdy1", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prio_m = 0;
        for (int i = 0; i < 5; i++) begin
            chk("rexec_v0", rsp0_valid, 0);
            chk("rexec_v1", rsp1_valid, 0);
            @(negedge clk);
        end
        set_req(0, 1'b1, 3'd7, 64'd5, 64'd9);
        set_req(1, 1'b1, 3'd1, 64'd1, 64'd2);
        #1;
        chk("rexec_prio_rdy0", req0_ready, 1);
        chk("rexec_prio_rdy1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(0, 64'd0, 6'b000000, 1'b1, 0, "illegal");
        chk("after_ill_rdy1", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        finish_op(1, 64'd3, 6'b000001, 1'b0, 0, "after_ill");

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            f0 = 3'($urandom_range(0, 7));
            f1 = 3'($urandom_range(0, 7));
            a0 = rnd64();
            b0 = ($urandom_range(0, 4) == 0) ? a0 : rnd64();
            a1 = rnd64();
            b1 = ($urandom_range(0, 4) == 0) ? a1 : rnd64();
            d = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) begin
                w = prio_m;
                l = 1 - w;
                set_req(0, 1'b1, f0, a0, b0);
                set_req(1, 1'b1, f1, a1, b1);
                #1;
                chk("rnd_arb_rdy0", req0_ready, (w == 0));
                chk("rnd_arb_rdy1", req1_ready, (w == 1));
                @(posedge clk);
                @(negedge clk);
                set_req(w, 1'b0, 3'd0, 64'd0, 64'd0);
                if (w == 0) model(f0, a0, b0, er, ef, ee);
                else model(f1, a1, b1, er, ef, ee);
                finish_op(w, er, ef, ee, d, "rnd_win");
                chk("rnd_lose_rdy", (l == 0) ? req0_ready : req1_ready, 1);
                @(posedge clk);
                @(negedge clk);
                set_req(l, 1'b0, 3'd0, 64'd0, 64'd0);
                if (l == 0) model(f0, a0, b0, er, ef, ee);
                else model(f1, a1, b1, er, ef, ee);
                finish_op(l, er, ef, ee, 0, "rnd_lose");
            end else begin
                w = $urandom_range(0, 1);
                model(f0, a0, b0, er, ef, ee);
                lone_op(w, f0, a0, b0, er, ef, ee, d, "rnd_lone");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
